memwb_skid_reg: RTL and testbench

//  Memory->writeback pipeline register with a 2-entry skid buffer; sits directly upstream of the

---
 rtl/common_pkg.sv | 5 +
 rtl/pipes_pkg.sv | 24 ++
 rtl/skid_slot.sv | 25 ++
 rtl/memwb_skid_reg.sv | 71 +++++++
 tb/tb_memwb_skid_reg.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/common_pkg.sv
// rtl/common_pkg.sv - shared scalar/word typedefs
package common;
    typedef logic        u1;
    typedef logic [63:0] u64;
endpackage

// File: rtl/pipes_pkg.sv
// rtl/pipes_pkg.sv - pipeline payload types and the writeback bubble constant
package pipes;
    import common::*;

    typedef enum logic [2:0] {
        OP_ALU   = 3'd0,
        OP_LOAD  = 3'd1,
        OP_STORE = 3'd2,
        OP_JUMP  = 3'd3,
        OP_CSR   = 3'd4,
        FLUSH    = 3'd7
    } op_t;

    typedef struct packed {
        u64         pc;
        op_t        op;
        logic [4:0] dst;
        u1          regwrite;
        u64         wdata;
    } writeback_data_t;

    localparam writeback_data_t WB_BUBBLE = '{pc: 64'd0, op: FLUSH, dst: 5'd0,
                                              regwrite: 1'b0, wdata: 64'd0};
endpackage

// File: rtl/skid_slot.sv
// rtl/skid_slot.sv - one valid+data holding register with load/clear
module skid_slot
    import pipes::*;
(
    input  logic            clk,
    input  logic            reset_n,
    input  logic            load,
    input  logic            clear,
    input  writeback_data_t d,
    output logic            valid,
    output writeback_data_t q
);
    // clear wins over load so a squash can never be undone by a same-cycle fill
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid <= 1'b0;
            q     <= WB_BUBBLE;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end
    end
endmodule

// File: rtl/memwb_skid_reg.sv
// rtl/memwb_skid_reg.sv - MEM->WB register with 2-entry skid, regfile port and instret
module memwb_skid_reg
    import common::*;
    import pipes::*;
#(
    parameter int INSTRET_W = 64
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  writeback_data_t      dataM,
    input  logic                 m_valid,
    output logic                 m_ready,
    input  logic                 wb_stall,
    input  logic                 flush,
    output writeback_data_t      dataW,
    output logic                 rf_wen,
    output logic [4:0]           rf_waddr,
    output logic [63:0]          rf_wdata,
    output logic [INSTRET_W-1:0] instret
);
    logic            head_valid, skid_valid;
    writeback_data_t head_q, skid_q, head_d;
    logic            head_load, head_clear, skid_load, skid_clear;
    logic            in_valid, accept, retire;

    // m_ready derives only from the skid register, never from wb_stall
    assign m_ready  = !skid_valid;
    assign in_valid = m_valid && (dataM.op != FLUSH);
    assign accept   = in_valid && m_ready && !flush;
    assign retire   = head_valid && !wb_stall && !flush;

    assign head_d     = skid_valid ? skid_q : dataM;
    assign head_load  = !flush && ((retire && (skid_valid || accept)) || (!head_valid && accept));
    assign head_clear = flush || (retire && !skid_valid && !accept);
    // accept implies an empty skid, so on retire the skid always drains into head
    assign skid_load  = !flush && !retire && head_valid && accept;
    assign skid_clear = flush || retire;

    skid_slot u_head (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (head_load),
        .clear   (head_clear),
        .d       (head_d),
        .valid   (head_valid),
        .q       (head_q)
    );

    skid_slot u_skid (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (skid_load),
        .clear   (skid_clear),
        .d       (dataM),
        .valid   (skid_valid),
        .q       (skid_q)
    );

    assign dataW    = head_valid ? head_q : WB_BUBBLE;
    assign rf_wen   = retire && head_q.regwrite && (head_q.dst != 5'd0);
    assign rf_waddr = dataW.dst;
    assign rf_wdata = dataW.wdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instret <= '0;
        end else if (retire) begin
            instret <= instret + INSTRET_W'(1);
        end
    end
endmodule

// File: tb/tb_memwb_skid_reg.sv
// tb/tb_memwb_skid_reg.sv - directed vector table plus queue-model random test
module tb_memwb_skid_reg;
    import common::*;
    import pipes::*;

    logic            clk = 1'b0;
    logic            reset_n;
    writeback_data_t dataM;
    logic            m_valid, m_ready, wb_stall, flush;
    writeback_data_t dataW;
    logic            rf_wen;
    logic [4:0]      rf_waddr;
    logic [63:0]     rf_wdata;
    logic [63:0]     instret;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    memwb_skid_reg #(.INSTRET_W(64)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .dataM    (dataM),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .wb_stall (wb_stall),
        .flush    (flush),
        .dataW    (dataW),
        .rf_wen   (rf_wen),
        .rf_waddr (rf_waddr),
        .rf_wdata (rf_wdata),
        .instret  (instret)
    );

    typedef struct {
        logic        mv;
        logic [63:0] pc;
        op_t         op;
        logic [4:0]  dst;
        logic        rw;
        logic [63:0] wd;
        logic        stall;
        logic        fl;
        logic        e_valid;
        logic [63:0] e_pc;
        logic        e_ready;
        logic        e_wen;
        logic [4:0]  e_waddr;
        logic [63:0] e_wdata;
        logic [63:0] e_instret;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic mv, input logic [63:0] pc, input op_t op,
                                input logic [4:0] dst, input logic rw, input logic [63:0] wd,
                                input logic stall, input logic fl, input logic e_valid,
                                input logic [63:0] e_pc, input logic e_ready, input logic e_wen,
                                input logic [4:0] e_waddr, input logic [63:0] e_wdata,
                                input logic [63:0] e_instret);
        vec_t v;
        v.mv = mv; v.pc = pc; v.op = op; v.dst = dst; v.rw = rw; v.wd = wd;
        v.stall = stall; v.fl = fl; v.e_valid = e_valid; v.e_pc = e_pc;
        v.e_ready = e_ready; v.e_wen = e_wen; v.e_waddr = e_waddr;
        v.e_wdata = e_wdata; v.e_instret = e_instret;
        return v;
    endfunction

    task automatic drive(input logic mv, input logic [63:0] pc, input op_t op,
                         input logic [4:0] dst, input logic rw, input logic [63:0] wd,
                         input logic stall, input logic fl);
        m_valid        = mv;
        dataM.pc       = pc;
        dataM.op       = op;
        dataM.dst      = dst;
        dataM.regwrite = rw;
        dataM.wdata    = wd;
        wb_stall       = stall;
        flush          = fl;
    endtask

    // Reference model: an ordered list of at most two in-flight instructions
    writeback_data_t mq[$];
    logic [63:0]     m_instret;

    initial begin
        reset_n = 1'b0;
        drive(1'b0, 64'd0, OP_ALU, 5'd0, 1'b0, 64'd0, 1'b0, 1'b0);

        // columns: mv pc op dst rw wdata stall flush | valid pc ready wen waddr wdata instret
        vecs.push_back(mk(1, 64'h8000_0000, OP_ALU, 1, 1, 64'h11, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 64'h8000_0004, OP_ALU, 2, 1, 64'h22, 0, 0, 1, 64'h8000_0000, 1, 1, 1, 64'h11, 0));
        vecs.push_back(mk(1, 64'h8000_0008, OP_LOAD, 3, 1, 64'h33, 0, 0, 1, 64'h8000_0004, 1, 1, 2, 64'h22, 1));
        vecs.push_back(mk(0, 0, OP_ALU, 0, 0, 0, 0, 0, 1, 64'h8000_0008, 1, 1, 3, 64'h33, 2));
        vecs.push_back(mk(0, 0, OP_ALU, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 3));
        vecs.push_back(mk(1, 64'h100, OP_STORE, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 3));
        vecs.push_back(mk(1, 64'h104, OP_STORE, 0, 0, 0, 1, 0, 1, 64'h100, 1, 0, 0, 0, 3));
        vecs.push_back(mk(0, 0, OP_ALU, 0, 0, 0, 1, 0, 1, 64'h100, 0, 0, 0, 0, 3));
        vecs.push_back(mk(0, 0, OP_ALU, 0, 0, 0, 0, 0, 1, 64'h100, 0, 0, 0, 0, 3));
        vecs.push_back(mk(0, 0, OP_ALU, 0, 0, 0, 0, 0, 1, 64'h104, 1, 0, 0, 0, 4));
        vecs.push_back(mk(0, 0, OP_ALU, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 5));
        vecs.push_back(mk(1, 64'h300, OP_ALU, 0, 1, 64'h55, 0, 0, 0, 0, 1, 0, 0, 0, 5));
        vecs.push_back(mk(1, 64'h304, OP_ALU, 5, 1, 64'hDEAD, 0, 0, 1, 64'h300, 1, 0, 0, 0, 5));
        vecs.push_back(mk(0, 0, OP_ALU, 0, 0, 0, 0, 0, 1, 64'h304, 1, 1, 5, 64'hDEAD, 6));
        vecs.push_back(mk(0, 0, OP_ALU, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 7));
        vecs.push_back(mk(1, 64'h180, OP_ALU, 6, 1, 64'h66, 1, 0, 0, 0, 1, 0, 0, 0, 7));
        vecs.push_back(mk(1, 64'h184, OP_ALU, 7, 1, 64'h77, 1, 0, 1, 64'h180, 1, 0, 0, 0, 7));
        vecs.push_back(mk(1, 64'h200, OP_ALU, 8, 1, 64'h88, 1, 1, 1, 64'h180, 0, 0, 0, 0, 7));
        vecs.push_back(mk(0, 0, OP_ALU, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 7));
        vecs.push_back(mk(0, 0, OP_ALU, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 7));
        vecs.push_back(mk(1, 64'h400, OP_ALU, 9, 1, 64'h99, 1, 0, 0, 0, 1, 0, 0, 0, 7));
        vecs.push_back(mk(1, 64'h404, OP_ALU, 9, 1, 64'h98, 0, 1, 1, 64'h400, 1, 0, 0, 0, 7));
        vecs.push_back(mk(1, 64'h500, FLUSH, 4, 1, 64'h44, 0, 0, 0, 0, 1, 0, 0, 0, 7));
        vecs.push_back(mk(0, 0, OP_ALU, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 7));

        repeat (2) @(posedge clk);
        #1;
        chk("reset_dataW", 192'(dataW), 192'(WB_BUBBLE));
        chk("reset_rf_wen", 192'(rf_wen), 192'(1'b0));
        chk("reset_m_ready", 192'(m_ready), 192'(1'b1));
        chk("reset_instret", 192'(instret), 192'(64'd0));
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].mv, vecs[i].pc, vecs[i].op, vecs[i].dst, vecs[i].rw, vecs[i].wd,
                  vecs[i].stall, vecs[i].fl);
            #2;
            if (vecs[i].e_valid) begin
                chk($sformatf("vec%0d_pc", i), 192'(dataW.pc), 192'(vecs[i].e_pc));
            end else begin
                chk($sformatf("vec%0d_bubble", i), 192'(dataW), 192'(WB_BUBBLE));
            end
            chk($sformatf("vec%0d_m_ready", i), 192'(m_ready), 192'(vecs[i].e_ready));
            chk($sformatf("vec%0d_rf_wen", i), 192'(rf_wen), 192'(vecs[i].e_wen));
            if (vecs[i].e_wen) begin
                chk($sformatf("vec%0d_rf_waddr", i), 192'(rf_waddr), 192'(vecs[i].e_waddr));
                chk($sformatf("vec%0d_rf_wdata", i), 192'(rf_wdata), 192'(vecs[i].e_wdata));
            end
            chk($sformatf("vec%0d_instret", i), 192'(instret), 192'(vecs[i].e_instret));
            @(posedge clk);
            #1;
        end

        // Async reset while stalled with both slots full
        drive(1, 64'h600, OP_ALU, 10, 1, 64'hA0, 1, 0);
        @(posedge clk); #1;
        drive(1, 64'h604, OP_ALU, 11, 1, 64'hA4, 1, 0);
        @(posedge clk); #1;
        drive(0, 64'd0, OP_ALU, 0, 0, 64'd0, 1, 0);
        #1;
        chk("arst_pre_pc", 192'(dataW.pc), 192'(64'h600));
        chk("arst_pre_ready", 192'(m_ready), 192'(1'b0));
        wb_stall = 1'b0;
        reset_n  = 1'b0;
        #1;
        chk("arst_dataW", 192'(dataW), 192'(WB_BUBBLE));
        chk("arst_rf_wen", 192'(rf_wen), 192'(1'b0));
        chk("arst_m_ready", 192'(m_ready), 192'(1'b1));
        chk("arst_instret", 192'(instret), 192'(64'd0));
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Randomised run against the queue model
        mq.delete();
        m_instret = 64'd0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            writeback_data_t d, exp_w;
            logic mv, st, fl, exp_ready, ret, exp_wen;
            d.pc       = {32'd0, $urandom()};
            d.op       = ($urandom_range(0, 9) == 0) ? FLUSH : op_t'($urandom_range(0, 4));
            d.dst      = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            d.regwrite = 1'($urandom_range(0, 1));
            d.wdata    = {$urandom(), $urandom()};
            mv = ($urandom_range(0, 9) < 7);
            st = ($urandom_range(0, 9) < 4);
            fl = ($urandom_range(0, 19) == 0);
            drive(mv, d.pc, d.op, d.dst, d.regwrite, d.wdata, st, fl);
            #2;
            exp_w     = (mq.size() > 0) ? mq[0] : WB_BUBBLE;
            exp_ready = (mq.size() < 2);
            ret       = (mq.size() > 0) && !st && !fl;
            exp_wen   = ret && exp_w.regwrite && (exp_w.dst != 5'd0);
            chk($sformatf("rnd%0d_dataW", cyc), 192'(dataW), 192'(exp_w));
            chk($sformatf("rnd%0d_m_ready", cyc), 192'(m_ready), 192'(exp_ready));
            chk($sformatf("rnd%0d_rf_wen", cyc), 192'(rf_wen), 192'(exp_wen));
            if (exp_wen) begin
                chk($sformatf("rnd%0d_rf_waddr", cyc), 192'(rf_waddr), 192'(exp_w.dst));
                chk($sformatf("rnd%0d_rf_wdata", cyc), 192'(rf_wdata), 192'(exp_w.wdata));
            end
            chk($sformatf("rnd%0d_instret", cyc), 192'(instret), 192'(m_instret));
            @(posedge clk);
            if (fl) begin
                mq.delete();
            end else begin
                if (ret) begin
                    void'(mq.pop_front());
                    m_instret = m_instret + 64'd1;
                end
                if (mv && (d.op != FLUSH) && exp_ready) mq.push_back(d);
            end
            #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
